// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcode and ALU select
// constants, instruction field positions and the raw control bundle type.
package cpu_ctrl_pkg;

  // Instruction word field positions
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 24;
  localparam int DEST_MSB = 23;
  localparam int DEST_LSB = 16;
  localparam int SRC1_MSB = 15;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_MSB = 7;
  localparam int SRC2_LSB = 0;

  // Opcodes
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  // ALU operation selects
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Raw decoded control bundle, before reset gating
  typedef struct packed {
    logic       we;
    logic [2:0] aluop;
    logic       comp;
    logic       imm;
    logic       jump;
    logic       branch;
  } ctrl_t;

  // All-inactive bundle used for undefined opcodes
  localparam ctrl_t CTRL_NONE = '{we: 1'b0, aluop: ALU_FWD, comp: 1'b0,
                                  imm: 1'b0, jump: 1'b0, branch: 1'b0};

endpackage

// File: rtl/control_decoder.sv
// Purely combinational opcode decoder. Maps OP[7:0] to the raw control
// bundle and flags undefined opcodes.
// Optional feature: CONTROL_UNIT_BRANCH_EN enables j (0x06) and beq (0x07);
// without it those opcodes are treated as illegal.
module control_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [7:0] op,
  output ctrl_t      ctrl,
  output logic       illegal
);

  // Opcode map lookup; anything not listed is illegal with all controls off
  always_comb begin
    ctrl    = CTRL_NONE;
    illegal = 1'b0;
    case (op)
      OP_LOADI: begin
        ctrl.we    = 1'b1;
        ctrl.aluop = ALU_FWD;
        ctrl.imm   = 1'b1;
      end
      OP_MOV: begin
        ctrl.we    = 1'b1;
        ctrl.aluop = ALU_FWD;
      end
      OP_ADD: begin
        ctrl.we    = 1'b1;
        ctrl.aluop = ALU_ADD;
      end
      OP_SUB: begin
        ctrl.we    = 1'b1;
        ctrl.aluop = ALU_ADD;
        ctrl.comp  = 1'b1;
      end
      OP_AND: begin
        ctrl.we    = 1'b1;
        ctrl.aluop = ALU_AND;
      end
      OP_OR: begin
        ctrl.we    = 1'b1;
        ctrl.aluop = ALU_OR;
      end
`ifdef CONTROL_UNIT_BRANCH_EN
      OP_J: begin
        ctrl.jump  = 1'b1;
      end
      OP_BEQ: begin
        // ALU computes SRC1 - SRC2 so PC logic can test ZERO
        ctrl.aluop  = ALU_ADD;
        ctrl.comp   = 1'b1;
        ctrl.branch = 1'b1;
      end
`endif
      default: begin
        ctrl    = CTRL_NONE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction decoder of the 8-bit single-cycle CPU. Wraps control_decoder,
// masks state-changing requests while RESET is high, and keeps a sticky
// record of any illegal opcode since reset.
// Optional feature: CONTROL_UNIT_BRANCH_EN enables j/beq decoding; when
// undefined, JUMP and BRANCH are constant 0.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  output logic        WRITEENABLE,
  output logic [2:0]  ALUOP,
  output logic        COMPLEMENT_FLAG,
  output logic        IMMEDIATE_FLAG,
  output logic        JUMP,
  output logic        BRANCH,
  output logic        ILLEGAL,
  output logic        ILLEGAL_SEEN
);

  ctrl_t      raw_ctrl;
  logic       raw_illegal;
  logic [7:0] op;
  logic       illegal_seen_q;

  // Operand fields are consumed by the datapath, not by this block
  logic unused_fields;
  assign unused_fields = ^INSTRUCTION[DEST_MSB:SRC2_LSB];

  assign op = INSTRUCTION[OP_MSB:OP_LSB];

  control_decoder u_decoder (
    .op      (op),
    .ctrl    (raw_ctrl),
    .illegal (raw_illegal)
  );

  // Reset gates only the requests that change architectural state;
  // operand-path selects keep following the decode
  always_comb begin
    WRITEENABLE     = raw_ctrl.we & ~RESET;
    ALUOP           = raw_ctrl.aluop;
    COMPLEMENT_FLAG = raw_ctrl.comp;
    IMMEDIATE_FLAG  = raw_ctrl.imm;
`ifdef CONTROL_UNIT_BRANCH_EN
    JUMP            = raw_ctrl.jump & ~RESET;
    BRANCH          = raw_ctrl.branch & ~RESET;
`else
    JUMP            = 1'b0;
    BRANCH          = 1'b0;
`endif
    ILLEGAL         = raw_illegal;
  end

  // Sticky illegal-opcode record; reset wins over a same-edge set
  always_ff @(posedge CLK) begin
    if (RESET) begin
      illegal_seen_q <= 1'b0;
    end else if (raw_illegal) begin
      illegal_seen_q <= 1'b1;
    end
  end

  assign ILLEGAL_SEEN = illegal_seen_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit. Builds with or without
// CONTROL_UNIT_BRANCH_EN and adapts its expectations accordingly.
module tb_control_unit;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        WRITEENABLE;
  logic [2:0]  ALUOP;
  logic        COMPLEMENT_FLAG;
  logic        IMMEDIATE_FLAG;
  logic        JUMP;
  logic        BRANCH;
  logic        ILLEGAL;
  logic        ILLEGAL_SEEN;

  int checks = 0;
  int errors = 0;

  // Expected decode word: {we, aluop[2:0], comp, imm, jump, branch, illegal}
  logic [8:0] exp_q[$];

  control_unit dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .INSTRUCTION     (INSTRUCTION),
    .WRITEENABLE     (WRITEENABLE),
    .ALUOP           (ALUOP),
    .COMPLEMENT_FLAG (COMPLEMENT_FLAG),
    .IMMEDIATE_FLAG  (IMMEDIATE_FLAG),
    .JUMP            (JUMP),
    .BRANCH          (BRANCH),
    .ILLEGAL         (ILLEGAL),
    .ILLEGAL_SEEN    (ILLEGAL_SEEN)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference opcode map
  function automatic logic [8:0] model(input logic [7:0] op);
    case (op)
      8'h00: model = {1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      8'h01: model = {1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      8'h02: model = {1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      8'h03: model = {1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      8'h04: model = {1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      8'h05: model = {1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef CONTROL_UNIT_BRANCH_EN
      8'h06: model = {1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      8'h07: model = {1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
      default: model = {1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    endcase
  endfunction

  function automatic logic [8:0] observed();
    observed = {WRITEENABLE, ALUOP, COMPLEMENT_FLAG, IMMEDIATE_FLAG,
                JUMP, BRANCH, ILLEGAL};
  endfunction

  // Driver: apply an instruction and let combinational outputs settle
  task automatic drive(input logic rst, input logic [31:0] instr);
    RESET       = rst;
    INSTRUCTION = instr;
    #1;
  endtask

  // Advance one rising edge and step clear of it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [8:0] exp_w;
    logic [8:0] gated;

    // Reset for one edge
    RESET       = 1'b1;
    INSTRUCTION = 32'h0;
    @(negedge CLK);
    tick();

    // loadi
    drive(1'b0, 32'h0000_0400);
    check("loadi_we",    32'(WRITEENABLE),     32'd1);
    check("loadi_aluop", 32'(ALUOP),           32'd0);
    check("loadi_imm",   32'(IMMEDIATE_FLAG),  32'd1);
    check("loadi_comp",  32'(COMPLEMENT_FLAG), 32'd0);
    check("loadi_ill",   32'(ILLEGAL),         32'd0);
    check("reset_seen",  32'(ILLEGAL_SEEN),    32'd0);

    // sub then or
    tick();
    drive(1'b0, 32'h0304_0602);
    check("sub_we",    32'(WRITEENABLE),     32'd1);
    check("sub_aluop", 32'(ALUOP),           32'd1);
    check("sub_comp",  32'(COMPLEMENT_FLAG), 32'd1);
    check("sub_imm",   32'(IMMEDIATE_FLAG),  32'd0);
    tick();
    drive(1'b0, 32'h0500_0400);
    check("or_we",    32'(WRITEENABLE),     32'd1);
    check("or_aluop", 32'(ALUOP),           32'd3);
    check("or_comp",  32'(COMPLEMENT_FLAG), 32'd0);
    tick();
    check("seen_legal_only", 32'(ILLEGAL_SEEN), 32'd0);

    // Undefined opcode, sticky flag
    drive(1'b0, 32'h0900_0200);
    check("undef_we",    32'(WRITEENABLE),  32'd0);
    check("undef_aluop", 32'(ALUOP),        32'd0);
    check("undef_ill",   32'(ILLEGAL),      32'd1);
    check("seen_pre",    32'(ILLEGAL_SEEN), 32'd0);
    tick();
    check("seen_set", 32'(ILLEGAL_SEEN), 32'd1);
    drive(1'b0, 32'h0201_0203);
    check("add_ill",   32'(ILLEGAL),     32'd0);
    check("add_we",    32'(WRITEENABLE), 32'd1);
    check("add_aluop", 32'(ALUOP),       32'd1);
    tick();
    check("seen_sticky", 32'(ILLEGAL_SEEN), 32'd1);

    // Reset with add applied
    drive(1'b1, 32'h0201_0203);
    check("rst_add_we",    32'(WRITEENABLE), 32'd0);
    check("rst_add_aluop", 32'(ALUOP),       32'd1);
    tick();
    check("seen_cleared", 32'(ILLEGAL_SEEN), 32'd0);

    // Reset has priority over an illegal opcode on the same edge
    drive(1'b1, 32'hFF00_0000);
    check("rst_ill_flag", 32'(ILLEGAL), 32'd1);
    tick();
    check("seen_rst_priority", 32'(ILLEGAL_SEEN), 32'd0);
    drive(1'b0, 32'hFF00_0000);
    tick();
    check("seen_after_release", 32'(ILLEGAL_SEEN), 32'd1);
    drive(1'b1, 32'h0000_0000);
    tick();
    check("seen_cleared2", 32'(ILLEGAL_SEEN), 32'd0);

    // Branch / jump opcodes
    drive(1'b0, 32'h0700_0102);
`ifdef CONTROL_UNIT_BRANCH_EN
    check("beq_branch", 32'(BRANCH),          32'd1);
    check("beq_we",     32'(WRITEENABLE),     32'd0);
    check("beq_aluop",  32'(ALUOP),           32'd1);
    check("beq_comp",   32'(COMPLEMENT_FLAG), 32'd1);
    check("beq_ill",    32'(ILLEGAL),         32'd0);
`else
    check("beq_ill",    32'(ILLEGAL), 32'd1);
    check("beq_branch", 32'(BRANCH),  32'd0);
    check("beq_jump",   32'(JUMP),    32'd0);
`endif
    drive(1'b0, 32'h0600_0000);
`ifdef CONTROL_UNIT_BRANCH_EN
    check("j_jump", 32'(JUMP),    32'd1);
    check("j_ill",  32'(ILLEGAL), 32'd0);
    // Reset masks jump and branch requests
    drive(1'b1, 32'h0600_0000);
    check("rst_j_jump", 32'(JUMP), 32'd0);
    drive(1'b1, 32'h0700_0102);
    check("rst_beq_branch", 32'(BRANCH), 32'd0);
    check("rst_beq_aluop",  32'(ALUOP),  32'd1);
`else
    check("j_ill",    32'(ILLEGAL), 32'd1);
    check("j_jump",   32'(JUMP),    32'd0);
    check("j_branch", 32'(BRANCH),  32'd0);
`endif

    // Full opcode sweep, operand fields randomised, reset released
    drive(1'b1, 32'h0);
    tick();
    for (int op = 0; op < 256; op++) begin
      exp_q.push_back(model(8'(op)));
      drive(1'b0, {8'(op), 24'($urandom_range(0, 24'hFF_FFFF))});
      exp_w = exp_q.pop_front();
      check($sformatf("sweep_op%02h", op), 32'(observed()), 32'(exp_w));
    end
    tick();
    check("seen_after_sweep", 32'(ILLEGAL_SEEN), 32'd1);

    // Same sweep held in reset: state-changing requests masked
    for (int op = 0; op < 256; op++) begin
      exp_w = model(8'(op));
      gated = exp_w & 9'b0_111_11_00_1;
      exp_q.push_back(gated);
      drive(1'b1, {8'(op), 24'($urandom_range(0, 24'hFF_FFFF))});
      exp_w = exp_q.pop_front();
      check($sformatf("rst_sweep_op%02h", op), 32'(observed()), 32'(exp_w));
    end
    tick();
    check("seen_after_rst_sweep", 32'(ILLEGAL_SEEN), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
